// File: rtl/mac8_pkg.sv
// Shared definitions for the MAC8 tile arithmetic blocks: default operand width,
// divider state encoding and a helper for sizing the iteration counter.
package mac8_pkg;

    localparam int DIV_WIDTH = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } divState_t;

    function automatic int divCntWidth(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division stage: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and restore if the result went negative.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_qMsb,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qBit
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    // The partial remainder is always below the divisor, so its shifted form
    // fits in WIDTH+1 bits and the kept remainder fits back into WIDTH bits.
    always_comb begin
        w_shift = {i_rem, i_qMsb};
        w_diff  = w_shift - {1'b0, i_div};
        o_qBit  = ~w_diff[WIDTH];
        o_rem   = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative radix-2 restoring divider with a start/busy/done handshake,
// producing one quotient bit per clock for unsigned WIDTH-bit operands.
module seq_restoring_divider
    import mac8_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = divCntWidth(WIDTH);

    divState_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_r;
    logic             r_zeroPend;

    logic [WIDTH-1:0] w_rem;
    logic             w_qBit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem  (r_r),
        .i_qMsb (r_q[WIDTH-1]),
        .i_div  (r_d),
        .o_rem  (w_rem),
        .o_qBit (w_qBit)
    );

    // A zero divisor bypasses CALC: r_zeroPend issues the flagged result one
    // edge after the start was accepted, and blocks a new start on that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_q         <= '0;
            r_d         <= '0;
            r_r         <= '0;
            r_zeroPend  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_zeroPend) begin
                        r_zeroPend  <= 1'b0;
                        done        <= 1'b1;
                        div_by_zero <= 1'b1;
                        quotient    <= '1;
                        remainder   <= r_q;
                    end else if (start) begin
                        r_q         <= dividend;
                        r_d         <= divisor;
                        r_r         <= '0;
                        r_cnt       <= CNT_W'(WIDTH);
                        div_by_zero <= 1'b0;
                        if (divisor != '0) begin
                            r_state <= ST_CALC;
                            busy    <= 1'b1;
                        end else begin
                            r_zeroPend <= 1'b1;
                        end
                    end
                end
                ST_CALC: begin
                    r_r   <= w_rem;
                    r_q   <= {r_q[WIDTH-2:0], w_qBit};
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        quotient  <= {r_q[WIDTH-2:0], w_qBit};
                        remainder <= w_rem;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Testbench for seq_restoring_divider: a cycle-level reference model checked every
// cycle, plus directed operations with hand-computed results.
module tb_seq_restoring_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int total = 0;
    int bad = 0;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference model: a result is computed with / and % when a start is
    // accepted and released after a fixed number of edges.
    logic         mBusy = 1'b0;
    logic         mDone = 1'b0;
    logic [W-1:0] mQ = '0;
    logic [W-1:0] mR = '0;
    logic         mDbz = 1'b0;
    logic [W-1:0] pendQ = '0;
    logic [W-1:0] pendR = '0;
    logic         pendZ = 1'b0;
    int           mLeft = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mBusy = 1'b0; mDone = 1'b0; mQ = '0; mR = '0; mDbz = 1'b0; mLeft = 0;
        end else begin
            mDone = 1'b0;
            if (mLeft > 0) begin
                mLeft--;
                if (mLeft == 0) begin
                    mDone = 1'b1; mBusy = 1'b0;
                    mQ = pendQ; mR = pendR; mDbz = pendZ;
                end
            end else if (start) begin
                mDbz = 1'b0;
                if (divisor == '0) begin
                    pendQ = '1; pendR = dividend; pendZ = 1'b1; mLeft = 1;
                end else begin
                    pendQ = dividend / divisor; pendR = dividend % divisor;
                    pendZ = 1'b0; mLeft = W; mBusy = 1'b1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(posedge clk) begin
        #2;
        checkOutput("busy", int'(busy), int'(mBusy));
        checkOutput("done", int'(done), int'(mDone));
        checkOutput("quotient", int'(quotient), int'(mQ));
        checkOutput("remainder", int'(remainder), int'(mR));
        checkOutput("div_by_zero", int'(div_by_zero), int'(mDbz));
    end

    // Called at a negedge; leaves start high across exactly one rising edge.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(output int busyCycles, output int waited);
        busyCycles = 0;
        waited = 1;
        while (done !== 1'b1 && waited < 40) begin
            if (busy === 1'b1) busyCycles++;
            @(negedge clk);
            waited++;
        end
        if (done !== 1'b1) begin
            bad++; total++;
            $display("[TB] FAIL done_timeout: got done=%0b expected 1", done);
        end
    endtask

    task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int expQ, input int expR, input int expZ);
        int bc, wt;
        applyStimulus(a, b);
        waitDone(bc, wt);
        checkOutput($sformatf("q %0d/%0d", a, b), int'(quotient), expQ);
        checkOutput($sformatf("r %0d/%0d", a, b), int'(remainder), expR);
        checkOutput($sformatf("dbz %0d/%0d", a, b), int'(div_by_zero), expZ);
    endtask

    initial begin
        int bc, wt;
        repeat (2) @(negedge clk);
        checkOutput("reset quotient", int'(quotient), 0);
        checkOutput("reset busy", int'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic division with latency and busy-width checks
        applyStimulus(8'd200, 8'd7);
        waitDone(bc, wt);
        checkOutput("200/7 busy cycles", bc, 8);
        checkOutput("200/7 latency", wt, 9);
        checkOutput("200/7 q", int'(quotient), 28);
        checkOutput("200/7 r", int'(remainder), 4);
        checkOutput("200/7 dbz", int'(div_by_zero), 0);
        @(negedge clk);
        checkOutput("done single pulse", int'(done), 0);

        runOp(8'd255, 8'd1, 255, 0, 0);
        runOp(8'd5, 8'd9, 0, 5, 0);
        runOp(8'd0, 8'd3, 0, 0, 0);
        runOp(8'd255, 8'd255, 1, 0, 0);

        // Divide by zero, then a normal division clears the flag
        applyStimulus(8'd77, 8'd0);
        waitDone(bc, wt);
        checkOutput("77/0 busy cycles", bc, 0);
        checkOutput("77/0 latency", wt, 2);
        checkOutput("77/0 q", int'(quotient), 255);
        checkOutput("77/0 r", int'(remainder), 77);
        checkOutput("77/0 dbz", int'(div_by_zero), 1);
        @(negedge clk);
        runOp(8'd77, 8'd7, 11, 0, 0);

        // Start while busy is ignored; start in the done cycle is accepted
        applyStimulus(8'd100, 8'd3);
        @(negedge clk);
        applyStimulus(8'd9, 8'd9);
        waitDone(bc, wt);
        checkOutput("100/3 q", int'(quotient), 33);
        checkOutput("100/3 r", int'(remainder), 1);
        applyStimulus(8'd9, 8'd9);
        checkOutput("b2b busy", int'(busy), 1);
        checkOutput("b2b held q", int'(quotient), 33);
        waitDone(bc, wt);
        checkOutput("9/9 q", int'(quotient), 1);
        checkOutput("9/9 r", int'(remainder), 0);
        @(negedge clk);

        // Asynchronous reset mid-operation
        applyStimulus(8'd200, 8'd7);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort busy", int'(busy), 0);
        checkOutput("abort done", int'(done), 0);
        checkOutput("abort quotient", int'(quotient), 0);
        checkOutput("abort remainder", int'(remainder), 0);
        checkOutput("abort dbz", int'(div_by_zero), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        runOp(8'd50, 8'd6, 8, 2, 0);

        // Random back-to-back sweep, each new start issued in the done cycle
        for (int i = 0; i < 1500; i++) begin
            logic [W-1:0] a, b;
            a = W'($urandom_range(0, 255));
            b = (i % 50 == 0) ? '0 : W'($urandom_range(0, 255));
            applyStimulus(a, b);
            waitDone(bc, wt);
        end
        @(negedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
